// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and constants for the CORDIC gain compensator
// Contents: gain_state_t FSM encoding, CORDIC_K_32 gain constant (0.6072529350 * 2^32).
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } gain_state_t;

  localparam logic [31:0] CORDIC_K_32 = 32'h9B74EDA8;

endpackage

// File: rtl/cordic_shift_add_mul.sv
// rtl/cordic_shift_add_mul.sv - iterative signed x unsigned-constant shift-add multiplier
// Ports: clk, reset (sync, active-high); start latches operand and clears acc;
//        step with index j adds sext(operand) << j into acc when K[j] is set;
//        acc is the signed 2*BIT_WIDTH+1 bit running product.
module cordic_shift_add_mul
  import cordic_pkg::*;
#(
  parameter int                   BIT_WIDTH       = 32,
  parameter int                   LOG_2_BIT_WIDTH = 5,
  parameter logic [BIT_WIDTH-1:0] K               = CORDIC_K_32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           step,
  input  logic [LOG_2_BIT_WIDTH-1:0]     j,
  input  logic signed [BIT_WIDTH-1:0]    operand,
  output logic signed [2*BIT_WIDTH:0]    acc
);

  logic signed [BIT_WIDTH-1:0]   op_reg;
  logic signed [2*BIT_WIDTH:0]   op_ext;

  // Sign-extend to the full accumulator width before shifting so the
  // largest partial product (shift of BIT_WIDTH-1) keeps its sign bit.
  assign op_ext = {{(BIT_WIDTH+1){op_reg[BIT_WIDTH-1]}}, op_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg <= '0;
      acc    <= '0;
    end else if (start) begin
      op_reg <= operand;
      acc    <= '0;
    end else if (step && K[j]) begin
      acc <= acc + (op_ext <<< j);
    end
  end

endmodule

// File: rtl/cordic_gain_comp.sv
// rtl/cordic_gain_comp.sv - removes CORDIC gain K from x/y with a valid/ready handshake
// Ports: clk, reset (sync, active-high); in_valid/in_ready with in_x, in_y, in_angle;
//        out_valid/out_ready with out_x, out_y (scaled by K) and out_angle (passed through).
// Option: define CORDIC_GAIN_ROUND_EN to round half up; otherwise results are floored.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int                   BIT_WIDTH       = 32,
  parameter int                   LOG_2_BIT_WIDTH = 5,
  parameter logic [BIT_WIDTH-1:0] K               = CORDIC_K_32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] in_x,
  input  logic signed [BIT_WIDTH-1:0] in_y,
  input  logic signed [BIT_WIDTH-1:0] in_angle,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BIT_WIDTH-1:0] out_x,
  output logic signed [BIT_WIDTH-1:0] out_y,
  output logic signed [BIT_WIDTH-1:0] out_angle
);

`ifdef CORDIC_GAIN_ROUND_EN
  localparam logic signed [2*BIT_WIDTH:0] ROUND = (2*BIT_WIDTH+1)'(1) <<< (BIT_WIDTH-1);
`else
  localparam logic signed [2*BIT_WIDTH:0] ROUND = '0;
`endif

  gain_state_t                  state;
  logic [LOG_2_BIT_WIDTH-1:0]   j;
  logic                         last;
  logic signed [BIT_WIDTH-1:0]  angle_reg;
  logic signed [2*BIT_WIDTH:0]  acc_x;
  logic signed [2*BIT_WIDTH:0]  acc_y;
  logic                         start;
  logic                         step;

  assign start = (state == IDLE) && in_valid;
  // The cycle after the final step only folds the accumulators into the
  // output registers, so no partial product is added then.
  assign step  = (state == MUL) && !last;

  cordic_shift_add_mul #(
    .BIT_WIDTH       (BIT_WIDTH),
    .LOG_2_BIT_WIDTH (LOG_2_BIT_WIDTH),
    .K               (K)
  ) u_mul_x (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .step    (step),
    .j       (j),
    .operand (in_x),
    .acc     (acc_x)
  );

  cordic_shift_add_mul #(
    .BIT_WIDTH       (BIT_WIDTH),
    .LOG_2_BIT_WIDTH (LOG_2_BIT_WIDTH),
    .K               (K)
  ) u_mul_y (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .step    (step),
    .j       (j),
    .operand (in_y),
    .acc     (acc_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      j         <= '0;
      last      <= 1'b0;
      angle_reg <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_angle <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            angle_reg <= in_angle;
            j         <= '0;
            last      <= 1'b0;
            in_ready  <= 1'b0;
            state     <= MUL;
          end
        end
        MUL: begin
          if (last) begin
            // Drop the Q0.BIT_WIDTH fraction; the K < 1 bound keeps the
            // remaining value inside BIT_WIDTH bits.
            out_x     <= BIT_WIDTH'((acc_x + ROUND) >>> BIT_WIDTH);
            out_y     <= BIT_WIDTH'((acc_y + ROUND) >>> BIT_WIDTH);
            out_angle <= angle_reg;
            out_valid <= 1'b1;
            last      <= 1'b0;
            state     <= DONE;
          end else if (j == LOG_2_BIT_WIDTH'(BIT_WIDTH-1)) begin
            j    <= '0;
            last <= 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// tb/tb_cordic_gain_comp.sv - self-checking bench for cordic_gain_comp
module tb_cordic_gain_comp;

  localparam int          W  = 32;
  localparam logic [31:0] KC = 32'h9B74EDA8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x, in_y, in_angle;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x, out_y, out_angle;

  int n_vec = 0;
  int n_err = 0;

  cordic_gain_comp #(
    .BIT_WIDTH       (W),
    .LOG_2_BIT_WIDTH (5),
    .K               (KC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_angle  (in_angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_angle (out_angle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: exact rational product v*K/2^32, then floor (or round half up).
  function automatic logic [31:0] model(input logic [31:0] v);
    longint p;
    p = longint'($signed(v)) * longint'({32'b0, KC});
`ifdef CORDIC_GAIN_ROUND_EN
    p = p + 64'sd2147483648;
`endif
    return 32'(p >>> 32);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one input and waits for out_valid; leaves the result pending.
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] a, input logic [31:0] ex, input logic [31:0] ey);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      tick;
      cnt++;
    end
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_x     = x;
    in_y     = y;
    in_angle = a;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      tick;
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(W + 1));
    chk({tag, "_x"}, out_x, ex);
    chk({tag, "_y"}, out_y, ey);
    chk({tag, "_angle"}, out_angle, a);
  endtask

  initial begin
    logic [31:0] rx, ry, ra;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_angle  = '0;
    out_ready = 1'b1;
    tick;
    tick;
    reset = 1'b0;

    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_x", out_x, 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    chk("rst_out_angle", out_angle, 32'd0);

    // Basic vector with distinct rounding result on the negative side.
`ifdef CORDIC_GAIN_ROUND_EN
    do_op("k1000", 32'd1000, -32'sd1000, 32'd123, 32'd607, -32'sd607);
`else
    do_op("k1000", 32'd1000, -32'sd1000, 32'd123, 32'd607, -32'sd608);
`endif
    tick;
    chk("k1000_done_valid", {31'b0, out_valid}, 32'd0);
    chk("k1000_done_ready", {31'b0, in_ready}, 32'd1);

    // Extremes with backpressure; in_valid pulses must be ignored.
    out_ready = 1'b0;
    do_op("ext", 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678,
          32'd1304065747, -32'sd1304065748);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_x     = 32'd5 + 32'(i);
      in_y     = 32'd9;
      in_angle = 32'd77;
      tick;
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_x", out_x, 32'd1304065747);
      chk("bp_y", out_y, -32'sd1304065748);
      chk("bp_angle", out_angle, 32'h1234_5678);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick;
    chk("bp_no_accept", {31'b0, in_ready}, 32'd1);

    // Back-to-back: second input offered during the first result's handshake.
    do_op("b2b_a", 32'd40000, 32'd3, 32'd1, model(32'd40000), model(32'd3));
    in_x     = -32'sd77777;
    in_y     = 32'd55555;
    in_angle = 32'd2;
    in_valid = 1'b1;
    tick;
    chk("b2b_gap_ready", {31'b0, in_ready}, 32'd1);
    chk("b2b_gap_valid", {31'b0, out_valid}, 32'd0);
    do_op("b2b_b", -32'sd77777, 32'd55555, 32'd2, model(-32'sd77777), model(32'd55555));

    // Reset in the middle of a multiply discards it.
    tick;
    in_x     = 32'd999;
    in_y     = 32'd999;
    in_angle = 32'd999;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_out_x", out_x, 32'd0);
    chk("abort_out_y", out_y, 32'd0);
    chk("abort_out_angle", out_angle, 32'd0);
    tick;
    chk("abort_stays_idle", {31'b0, out_valid}, 32'd0);
    do_op("zero", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    tick;

    // Smallest nonzero input exposes the rounding mode.
`ifdef CORDIC_GAIN_ROUND_EN
    do_op("one", 32'd0, 32'd1, 32'd5, 32'd0, 32'd1);
`else
    do_op("one", 32'd0, 32'd1, 32'd5, 32'd0, 32'd0);
`endif
    tick;

    // Random vectors against the reference product.
    for (int i = 0; i < 16; i++) begin
      rx = $urandom;
      ry = $urandom;
      ra = $urandom;
      do_op("rand", rx, ry, ra, model(rx), model(ry));
      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
